// File: rtl/render_cmd_packer.sv
// HPS byte-register front end that assembles 6-byte render commands and
// pushes each completed word into the render queue, tolerating queue back-pressure.
module render_cmd_packer #(
  parameter int unsigned WORD_BYTES = 6,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                    clk50,
  input  logic                    reset_reg,
  input  logic                    hps_chipselect,
  input  logic                    hps_write,
  input  logic                    hps_read,
  input  logic [2:0]              hps_address,
  input  logic [7:0]              hps_writedata,
  output logic [7:0]              hps_readdata,
  input  logic                    q_full,
  output logic                    q_we,
  output logic [WORD_BYTES*8-1:0] q_din,
  output logic                    busy
);

  localparam int unsigned     WORD_W      = WORD_BYTES * 8;
  localparam logic [2:0]      COMMIT_ADDR = 3'(WORD_BYTES - 1);
  localparam logic [2:0]      CTRL_ADDR   = 3'd6;
  localparam logic [2:0]      DROP_ADDR   = 3'd7;
  localparam logic [3:0]      ERR_MAX     = 4'hF;
  localparam logic [CNT_W-1:0] DROP_MAX   = '1;

  typedef enum logic [1:0] {IDLE, PUSH, STALL} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              byte_q [WORD_BYTES];
  logic [7:0]              byte_d [WORD_BYTES];
  logic [WORD_BYTES-1:0]   mask_q, mask_d;
  logic [WORD_W-1:0]       stage_q, stage_d;
  logic [3:0]              err_q, err_d;
  logic [CNT_W-1:0]        drop_q, drop_d;
  logic [7:0]              rdata_q, rdata_d;
  logic [WORD_W-1:0]       word_c;

  logic wr_c, rd_c, stall_c, free_c;

  assign wr_c    = hps_chipselect && hps_write;
  assign rd_c    = hps_chipselect && hps_read;
  assign stall_c = (state_q == STALL);
  // Staging can take a new word when empty or when its word leaves this cycle.
  assign free_c  = (state_q == IDLE) || ((state_q == PUSH) && !q_full);

  assign busy         = (state_q != IDLE);
  assign q_din        = stage_q;
  assign hps_readdata = rdata_q;

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    mask_d  = mask_q;
    stage_d = stage_q;
    err_d   = err_q;
    drop_d  = drop_q;
    rdata_d = rdata_q;
    q_we    = 1'b0;
    word_c  = '0;

    case (state_q)
      IDLE:  state_d = IDLE;
      PUSH: begin
        if (q_full) begin
          state_d = STALL;
        end else begin
          q_we    = 1'b1;
          state_d = IDLE;
        end
      end
      STALL: if (!q_full) state_d = PUSH;
      default: state_d = IDLE;
    endcase

    if (wr_c) begin
      for (int unsigned k = 0; k < WORD_BYTES; k++) begin
        if (hps_address == 3'(k)) begin
          byte_d[k] = hps_writedata;
          mask_d[k] = 1'b1;
        end
      end

      // Commit sees the final byte already latched and its mask bit set.
      if (hps_address == COMMIT_ADDR) begin
        mask_d = '0;
        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
          word_c[WORD_W-1-8*k -: 8] = byte_d[k];
        end
        if (&(mask_q | {1'b1, {(WORD_BYTES-1){1'b0}}})) begin
          if (free_c) begin
            stage_d = word_c;
            state_d = PUSH;
          end else if (drop_q != DROP_MAX) begin
            drop_d = drop_q + CNT_W'(1);
          end
        end else if (err_q != ERR_MAX) begin
          err_d = err_q + 4'd1;
        end
      end

      if (hps_address == CTRL_ADDR) begin
        if (hps_writedata[0]) begin
          err_d  = '0;
          drop_d = '0;
        end
        if (hps_writedata[1]) mask_d = '0;
      end
    end

    if (rd_c) begin
      if (hps_address == CTRL_ADDR) begin
        rdata_d = {err_q, 1'b0, stall_c, busy, &mask_q};
      end else if (hps_address == DROP_ADDR) begin
        rdata_d = 8'(drop_q);
      end else begin
        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
          if (hps_address == 3'(k)) rdata_d = byte_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk50 or posedge reset_reg) begin
    if (reset_reg) begin
      state_q <= IDLE;
      mask_q  <= '0;
      stage_q <= '0;
      err_q   <= '0;
      drop_q  <= '0;
      rdata_q <= '0;
      for (int unsigned k = 0; k < WORD_BYTES; k++) byte_q[k] <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      stage_q <= stage_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      rdata_q <= rdata_d;
      for (int unsigned k = 0; k < WORD_BYTES; k++) byte_q[k] <= byte_d[k];
    end
  end

endmodule

// File: doc/render_cmd_packer.md
RENDER_CMD_PACKER -- requirements
Module: render_cmd_packer

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 6: number of HPS bytes per render command.
REQ-002 SHALL have parameter CNT_W, default 8: width of the drop counter.
REQ-003 SHALL have port clk50  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset_reg  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port hps_chipselect  input  1  HPS slave select.
REQ-006 SHALL have port hps_write  input  1  HPS write strobe, qualified by chipselect.
REQ-007 SHALL have port hps_read  input  1  HPS read strobe, qualified by chipselect.
REQ-008 SHALL have port hps_address  input  3  register index.
REQ-009 SHALL have port hps_writedata  input  8  write byte.
REQ-010 SHALL have port hps_readdata  output  8  registered read data.
REQ-011 SHALL have port q_full  input  1  render queue cannot accept a word.
REQ-012 SHALL have port q_we  output  1  one-cycle push strobe to the render queue.
REQ-013 SHALL have port q_din  output  48  command word; valid while q_we=1.
REQ-014 SHALL have port busy  output  1  a staged word is awaiting push.

Function
REQ-015 SHALL latch a write to address k (0..5) into byte register k, mapped to q word bits [47-8k:40-8k], and SHALL set mask bit k.
REQ-016 SHALL treat a write to address 5 as a commit, evaluated with mask bit 5 already counted as set.
REQ-017 SHALL, on a commit with all 6 mask bits set, copy the assembled word into the staging register, clear the mask and keep the byte registers unchanged.
REQ-018 SHALL, on a commit with an incomplete mask, discard the commit, clear the mask and increment the 4-bit error counter, saturating at 15.
REQ-019 SHALL implement states IDLE, PUSH and STALL; its encoding is local.
REQ-020 SHALL go from IDLE to PUSH on an accepted commit.
REQ-021 SHALL, in PUSH with q_full=0, assert q_we for exactly that cycle with q_din = staging register, then go to IDLE.
REQ-022 SHALL go from PUSH to STALL when q_full=1, with q_we=0.
REQ-023 SHALL go from STALL to PUSH on the first cycle with q_full=0.
REQ-024 SHALL never assert q_we while q_full=1.
REQ-025 SHALL hold q_din stable from commit until the push completes.
REQ-026 SHALL treat the staging register as free in IDLE, or in PUSH with q_full=0.
REQ-027 SHALL accept a commit arriving in the same cycle as a completing push into the staging register and SHALL remain in PUSH, giving back-to-back pushes with no lost word.
REQ-028 SHALL drop a valid commit that arrives while the staging register is not free, clear the mask and increment the drop counter, saturating at 2^CNT_W-1.
REQ-029 SHALL keep accepting byte writes (addresses 0..5) in every state.
REQ-030 SHALL accept a write to address 6 as control: bit0=1 clears both counters, bit1=1 clears the mask; both actions in the same cycle are allowed.
REQ-031 SHALL have writes to address 7 take no effect.
REQ-032 SHALL return a read one cycle after the strobe: addr 0..5 = byte register; addr 6 = {err_cnt[3:0], 1'b0, stall, busy, mask==6'h3F}; addr 7 = drop_cnt (low 8 bits).
REQ-033 SHALL hold hps_readdata when no read occurs.
REQ-034 SHALL drive busy=1 in PUSH and STALL, and busy=0 in IDLE.
REQ-035 SHALL ignore a write that has chipselect=0.
REQ-036 SHALL give write priority over read when both strobes are high in the same cycle; readdata still updates.

Reset
REQ-037 SHALL, while reset_reg=1, immediately force state=IDLE, q_we=0, q_din=0, busy=0, hps_readdata=0, mask=0, byte registers=0, and both counters=0.
REQ-038 SHALL discard a staged word when reset is asserted in PUSH or STALL, and SHALL not emit q_we after reset release until a new commit.
REQ-039 SHALL begin operation on the first posedge clk50 after reset_reg deasserts.

Verification
REQ-040 SHALL be verified: write 0x11,0x22,0x33,0x44,0x55,0x66 to addr 0..5 with q_full=0 -> exactly one q_we with q_din=48'h112233445566, 1 cycle after the addr-5 write; busy back to 0.
REQ-041 SHALL be verified: write only addr 0,1,5 -> no q_we; addr 6 read returns err_cnt=1 and mask bit 0.
REQ-042 SHALL be verified: q_full=1, commit word A, hold q_full 10 cycles -> q_we=0 throughout, stall=1, busy=1; release q_full -> one q_we with word A.
REQ-043 SHALL be verified: during STALL, rewrite bytes and commit word B -> drop_cnt=1; after release only word A is pushed; addr 0..5 still read B's bytes.
REQ-044 SHALL be verified: commit in the same cycle a PUSH completes -> two consecutive q_we pulses carrying both words, drop_cnt=0.
REQ-045 SHALL be verified: assert reset_reg in STALL -> q_we stays 0 after release, and all reads return 0.
